hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
// Pipeline hazard/stall controller; it drives the ST bubble input of the ID/EX register.
// Compares the instruction in IF/ID against the ID/EX load destination.
// Generates PC/IF_ID hold, ID/EX bubble (ST), IF/ID flush and a global freeze for data-memory wait.
// Sits beside the decode stage; counts stall cycles for performance debug.
// PARAMETERS
// REG_W       4   register-number width (matches WN/RN1/RN2)
// LOAD_STALL  1   bubble cycles inserted per load-use hazard (1..15)
// CNT_W       16  width of saturating stall counter
// PORTS
// Clk           in   1      clock, rising edge
// Rst_n         in   1      asynchronous active-low reset
// IF_ID_RN1     in   REG_W  source reg 1 of instruction in ID
// IF_ID_RN2     in   REG_W  source reg 2 of instruction in ID
// IF_ID_UseRN2  in   1      1 = ID instruction actually reads RN2
// ID_EX_MR      in   1      instruction in EX is a load
// ID_EX_EnRW    in   1      instruction in EX writes a register
// ID_EX_WN      in   REG_W  destination reg of instruction in EX
// EX_Taken      in   1      branch resolved taken in EX this cycle
// MemBusy       in   1      data memory not ready; whole pipe must hold
// PCWrite       out  1      PC update enable
// IF_ID_Write   out  1      IF/ID load enable
// IF_ID_Flush   out  1      zero IF/ID on next edge
// ST            out  1      load bubble into ID/EX on next edge
// Freeze        out  1      hold ID/EX, EX/MEM, MEM/WB
// StallCount    out  CNT_W  saturating count of cycles with PCWrite=0
// BEHAVIOUR
// - FSM states: RUN, LDSTALL, FREEZE; state register, down-counter lcnt[3:0], resume register.
// - Reset (Rst_n=0, async): state=RUN, lcnt=0, StallCount=0; outputs forced PCWrite=0,
//   IF_ID_Write=0, IF_ID_Flush=1, ST=1, Freeze=0 while Rst_n=0. Release takes effect at the next edge.
// - Outputs are combinational from state + inputs (zero latency); ID/EX samples ST on the same edge.
// - hz = ID_EX_MR & ID_EX_EnRW & (ID_EX_WN!=0) & (WN==RN1 | (IF_ID_UseRN2 & WN==RN2)).
//   Reg 0 never hazards.
// - Priority per cycle: MemBusy > EX_Taken > LDSTALL/hz > normal.
// - MemBusy=1 (any state): Freeze=1, PCWrite=0, IF_ID_Write=0, ST=0, IF_ID_Flush=0.
//   resume <= current state; state <= FREEZE; lcnt holds. On MemBusy=0 in FREEZE: state <= resume,
//   and the outputs of the resumed state apply in that same cycle.
// - EX_Taken=1 (MemBusy=0): PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ST=1. Any LDSTALL is aborted:
//   state <= RUN, lcnt <= 0. The hz of the squashed ID instruction is ignored.
// - RUN with hz: PCWrite=0, IF_ID_Write=0, ST=1.
//   If LOAD_STALL==1, stay in RUN (the bubble clears hz).
//   Else state <= LDSTALL, lcnt <= LOAD_STALL-1.
// - LDSTALL: PCWrite=0, IF_ID_Write=0, ST=1; lcnt decrements each cycle.
//   When lcnt==1, state <= RUN, so there are exactly LOAD_STALL bubble cycles in total.
// - RUN, no hz: PCWrite=1, IF_ID_Write=1, ST=0, IF_ID_Flush=0, Freeze=0.
// - StallCount increments on every edge where PCWrite=0 and Rst_n=1 (including FREEZE);
//   it saturates at all-ones and never wraps.
// - Back-to-back load-use hazards each get the full LOAD_STALL bubbles; no merging.
// TESTING
// - Load r3 in EX (MR=1,EnRW=1,WN=3), ID RN1=3, LOAD_STALL=1 -> one cycle PCWrite=0, ST=1;
//   the next cycle (MR=0) PCWrite=1; StallCount=1.
// - Same hazard via RN2=3 with UseRN2=0 -> no stall. WN=0 with RN1=0 -> no stall.
// - LOAD_STALL=3, hazard -> ST=1 for exactly 3 cycles, then RUN; StallCount=3.
// - LDSTALL cycle 2 + MemBusy for 4 cycles -> Freeze=1, ST=0 for 4 cycles, then 1 more bubble; StallCount=7.
// - EX_Taken together with hz -> IF_ID_Flush=1, ST=1, PCWrite=1; state RUN next cycle.
// - Rst_n pulled low mid-LDSTALL -> outputs immediately take reset values;
//   after release, RUN with StallCount=0. Also check saturation with CNT_W=4: 20 stall cycles -> StallCount=15.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-stage hazard interface: hazard inputs from IF/ID and ID/EX, stall/flush controls back.
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
);
  logic [REG_W-1:0] IF_ID_RN1;
  logic [REG_W-1:0] IF_ID_RN2;
  logic             IF_ID_UseRN2;
  logic             ID_EX_MR;
  logic             ID_EX_EnRW;
  logic [REG_W-1:0] ID_EX_WN;
  logic             EX_Taken;
  logic             MemBusy;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ST;
  logic             Freeze;
  logic [CNT_W-1:0] StallCount;

  modport slave (
    input  IF_ID_RN1, IF_ID_RN2, IF_ID_UseRN2, ID_EX_MR, ID_EX_EnRW, ID_EX_WN,
           EX_Taken, MemBusy,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ST, Freeze, StallCount
  );

  modport master (
    output IF_ID_RN1, IF_ID_RN2, IF_ID_UseRN2, ID_EX_MR, ID_EX_EnRW, ID_EX_WN,
           EX_Taken, MemBusy,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ST, Freeze, StallCount
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard / stall controller beside decode: PC and IF/ID hold, ID/EX bubble,
// IF/ID flush on taken branch, global freeze while data memory is busy, stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned REG_W      = 4,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, LDSTALL, FREEZE} state_e;

  state_e           state_q, state_d;
  state_e           resume_q, resume_d;
  state_e           eff_state;
  logic [3:0]       lcnt_q, lcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hz;
  logic             pc_write, if_id_write, if_id_flush, st, freeze;

  // Load in EX whose destination feeds the instruction in ID; register 0 never hazards.
  always_comb begin
    hz = bus.ID_EX_MR && bus.ID_EX_EnRW && (bus.ID_EX_WN != '0) &&
         ((bus.ID_EX_WN == bus.IF_ID_RN1) ||
          (bus.IF_ID_UseRN2 && (bus.ID_EX_WN == bus.IF_ID_RN2)));
  end

  // Next state and outputs; FREEZE acts as its saved resume state once MemBusy drops,
  // so the resumed behaviour applies in the release cycle itself.
  always_comb begin
    state_d     = state_q;
    resume_d    = resume_q;
    lcnt_d      = lcnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    st          = 1'b0;
    freeze      = 1'b0;
    eff_state   = (state_q == FREEZE) ? resume_q : state_q;

    if (bus.MemBusy) begin
      freeze      = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      resume_d    = eff_state;
      state_d     = FREEZE;
    end else if (bus.EX_Taken) begin
      if_id_flush = 1'b1;
      st          = 1'b1;
      state_d     = RUN;
      lcnt_d      = '0;
    end else if (eff_state == LDSTALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      st          = 1'b1;
      lcnt_d      = lcnt_q - 4'd1;
      state_d     = (lcnt_q == 4'd1) ? RUN : LDSTALL;
    end else if (hz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      st          = 1'b1;
      if (LOAD_STALL == 1) begin
        state_d = RUN;
      end else begin
        state_d = LDSTALL;
        lcnt_d  = 4'(LOAD_STALL - 1);
      end
    end else begin
      state_d = RUN;
    end

    if (!Rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      st          = 1'b1;
      freeze      = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, bubble down-counter, resume state and stall counter registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= RUN;
      resume_q    <= RUN;
      lcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      lcnt_q      <= lcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IF_ID_Write = if_id_write;
  assign bus.IF_ID_Flush = if_id_flush;
  assign bus.ST          = st;
  assign bus.Freeze      = freeze;
  assign bus.StallCount  = stall_cnt_q;

endmodule
